// File: rtl/gpio_input_debouncer.sv
// gpio_input_debouncer
// Board-input conditioning for slide switches and push buttons. Each channel
// runs a two-flop synchroniser, a stability counter, a registered debounced
// level, one-cycle rise/fall strobes and a sticky change-event bit. The
// consumer clears the event bit with a per-bit clear. Channels are independent.

module gpio_input_debouncer #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 20,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic             SYSTEMCLOCK,
  input  logic             PUSH_BUTTON_RESET_RAW,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic [WIDTH-1:0] event_mask,
  output logic             event_any,
  input  logic [WIDTH-1:0] event_clear
);

  // Counter value at which a pending level change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [CNT_W-1:0] cnt_p2  [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] level_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [WIDTH-1:0] mask_nxt;

  // Bounded increment: holds at CNT_LAST rather than wrapping, so a stuck
  // mismatch can never alias back to a small count.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    if (c >= CNT_LAST) begin
      return CNT_LAST;
    end
    return c + CNT_W'(1);
  endfunction

  // ---- stage p0/p1: two-flop synchroniser, no logic between the flops ----
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      sync_p0 <= {WIDTH{INIT_LEVEL}};
      sync_p1 <= {WIDTH{INIT_LEVEL}};
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Per-channel stability decision on the synchronised input.
  always_comb begin
    level_nxt = level_out;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p1[i] == level_out[i]) begin
        // Input agrees with the accepted level: any bounce restarts the count.
        cnt_nxt[i] = '0;
      end else if (cnt_p2[i] == CNT_LAST) begin
        // Disagreement has lasted long enough: accept and strobe once.
        level_nxt[i] = sync_p1[i];
        rise_nxt[i]  = sync_p1[i];
        fall_nxt[i]  = ~sync_p1[i];
        cnt_nxt[i]   = '0;
      end else begin
        cnt_nxt[i] = cnt_step(cnt_p2[i]);
      end
    end
    // A new event in the same cycle as a clear survives the clear.
    mask_nxt = (event_mask & ~event_clear) | rise_nxt | fall_nxt;
  end

  // ---- stage p2: stability counters ----
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p2[i] <= cnt_nxt[i];
      end
    end
  end

  // ---- output stage: debounced level and one-cycle strobes ----
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      level_out <= {WIDTH{INIT_LEVEL}};
      rise_out  <= '0;
      fall_out  <= '0;
    end else begin
      level_out <= level_nxt;
      rise_out  <= rise_nxt;
      fall_out  <= fall_nxt;
    end
  end

  // Sticky event mask and its OR-reduction, registered together.
  always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
    if (!PUSH_BUTTON_RESET_RAW) begin
      event_mask <= '0;
      event_any  <= 1'b0;
    end else begin
      event_mask <= mask_nxt;
      event_any  <= |mask_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Testbench for gpio_input_debouncer: directed scenarios followed by random
// stimulus, every cycle compared with a window-based reference model.

module tb_gpio_input_debouncer;

  localparam int W = 4;
  localparam int D = 8;

  logic         SYSTEMCLOCK = 1'b0;
  logic         PUSH_BUTTON_RESET_RAW;
  logic [W-1:0] raw_in;
  logic [W-1:0] level_out, rise_out, fall_out, event_mask;
  logic         event_any;
  logic [W-1:0] event_clear;

  int errors = 0;
  int checks = 0;

  // Reference model state: raw samples taken at every post-reset edge.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_level, m_rise, m_fall, m_mask;
  logic         m_any;

  gpio_input_debouncer #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(20), .INIT_LEVEL(1'b0)
  ) dut (
    .SYSTEMCLOCK(SYSTEMCLOCK),
    .PUSH_BUTTON_RESET_RAW(PUSH_BUTTON_RESET_RAW),
    .raw_in(raw_in),
    .level_out(level_out),
    .rise_out(rise_out),
    .fall_out(fall_out),
    .event_mask(event_mask),
    .event_any(event_any),
    .event_clear(event_clear)
  );

  always #5 SYSTEMCLOCK = ~SYSTEMCLOCK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_mask  = '0;
    m_any   = 1'b0;
  endtask

  // The synchronised value seen at edge n is the raw sample from edge n-2.
  // A channel changes level at edge n when the synchronised values seen at
  // the last D edges (n-D+1..n) all differ from the current level.
  task automatic model_edge(input logic [W-1:0] r, input logic [W-1:0] c);
    int n;
    logic [W-1:0] nr;
    logic [W-1:0] nf;
    n  = hist.size();
    nr = '0;
    nf = '0;
    for (int i = 0; i < W; i++) begin
      bit all_diff;
      all_diff = (n >= D + 1);
      if (all_diff) begin
        for (int j = n - D - 1; j <= n - 2; j++) begin
          if (hist[j][i] == m_level[i]) all_diff = 0;
        end
      end
      if (all_diff) begin
        if (m_level[i]) nf[i] = 1'b1;
        else            nr[i] = 1'b1;
      end
    end
    m_level = m_level ^ (nr | nf);
    m_rise  = nr;
    m_fall  = nf;
    m_mask  = (m_mask & ~c) | nr | nf;
    m_any   = |m_mask;
    hist.push_back(r);
  endtask

  task automatic compare_all();
    chk("level", 32'(level_out), 32'(m_level));
    chk("rise",  32'(rise_out),  32'(m_rise));
    chk("fall",  32'(fall_out),  32'(m_fall));
    chk("mask",  32'(event_mask), 32'(m_mask));
    chk("any",   32'(event_any),  32'(m_any));
  endtask

  // One clock: drive inputs away from the edge, update model at the edge,
  // sample the DUT 1 time unit after it.
  task automatic tick(input logic [W-1:0] r, input logic [W-1:0] c);
    raw_in      = r;
    event_clear = c;
    @(posedge SYSTEMCLOCK);
    if (PUSH_BUTTON_RESET_RAW) model_edge(r, c);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    PUSH_BUTTON_RESET_RAW = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_level", 32'(level_out), 32'h0);
    for (int k = 0; k < cycles; k++) tick(raw_in, '0);
    PUSH_BUTTON_RESET_RAW = 1'b1;
  endtask

  // Ticks with constant inputs until bit b of the selected strobe fires;
  // returns the tick index (tick 0 is the first edge sampling the new value).
  task automatic wait_strobe(input logic [W-1:0] r, input int b, input bit use_fall,
                             output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      tick(r, '0);
      if (lat < 0 && (use_fall ? fall_out[b] : rise_out[b])) lat = k;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] r;
    raw_in                = '0;
    event_clear           = '0;
    PUSH_BUTTON_RESET_RAW = 1'b0;
    model_reset();

    // Reset with quiet inputs, then 20 idle cycles.
    do_reset(3);
    for (int k = 0; k < 20; k++) tick(4'b0000, '0);
    chk("idle_level", 32'(level_out), 32'h0);

    // Clean rise on channel 0: strobe at the 9th edge after first sample.
    wait_strobe(4'b0001, 0, 1'b0, lat);
    chk("lat_rise0", 32'(lat), 32'd9);
    chk("mask_after_rise0", 32'(event_mask), 32'h1);
    chk("any_after_rise0", 32'(event_any), 32'h1);

    // Glitch on channel 1 (high 5 cycles, low 2), then held high.
    for (int k = 0; k < 5; k++) tick(4'b0011, '0);
    for (int k = 0; k < 2; k++) tick(4'b0001, '0);
    chk("glitch_no_change", 32'(level_out[1]), 32'h0);
    wait_strobe(4'b0011, 1, 1'b0, lat);
    chk("lat_rise1", 32'(lat), 32'd9);

    // Clear channel 1 event, then clear channel 0 on the same edge its fall fires.
    tick(4'b0011, 4'b0010);
    chk("mask_only0", 32'(event_mask), 32'h1);
    for (int k = 0; k < 9; k++) tick(4'b0010, '0);
    tick(4'b0010, 4'b0001);
    chk("fall0_fires", 32'(fall_out[0]), 32'h1);
    chk("clr_vs_set", 32'(event_mask[0]), 32'h1);
    tick(4'b0010, 4'b0001);
    chk("clr_done", 32'(event_mask), 32'h0);
    chk("clr_any", 32'(event_any), 32'h0);

    // All channels low, clear, then simultaneous rise on all four.
    for (int k = 0; k < 12; k++) tick(4'b0000, '0);
    tick(4'b0000, 4'b1111);
    for (int k = 0; k < 9; k++) tick(4'b1111, '0);
    tick(4'b1111, '0);
    chk("rise_all", 32'(rise_out), 32'hF);
    tick(4'b1111, '0);
    chk("rise_all_once", 32'(rise_out), 32'h0);
    chk("level_all", 32'(level_out), 32'hF);

    // Reset mid-count on channel 2, then power-on state reported as an event.
    for (int k = 0; k < 12; k++) tick(4'b0000, '0);
    for (int k = 0; k < 7; k++) tick(4'b0100, '0);
    do_reset(3);
    chk("rst_rise", 32'(rise_out), 32'h0);
    chk("rst_mask", 32'(event_mask), 32'h0);
    wait_strobe(4'b0100, 2, 1'b0, lat);
    chk("lat_post_reset", 32'(lat), 32'd9);
    chk("mask_post_reset", 32'(event_mask), 32'h4);

    // Random stimulus: slow-changing inputs, random clears, occasional resets.
    r = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 15) == 0) r[i] = ~r[i];
      end
      if ($urandom_range(0, 299) == 0) begin
        raw_in = r;
        do_reset(int'($urandom_range(1, 3)));
      end
      tick(r, W'($urandom_range(0, 15)) & W'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
